fifo_wr_arbiter: RTL
====================

Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter that shares the async FIFO write port among NumReq requesters in the write clock domain.
- Grants are burst-locked: the owner keeps the port until its last beat or until MaxBurst beats have been accepted.
- Drives the FIFO write enable and data, and uses the FIFO full flag as backpressure.
- Single clock, so no CDC inside.

Parameters:
- NumReq, 4, number of requesters; at least 2.
- Width, 8, data width; matches the FIFO Width.
- MaxBurst, 16, maximum beats per grant before forced release; at least 1.

Ports:
- clk  input  1  write-domain clock; connects to the FIFO clk_wr.
- rst_n  input  1  asynchronous, active-low reset.
- i_req  input  NumReq  per-requester request; held high while the requester has data.
- i_data  input  NumReq*Width  per-requester data; requester k occupies bits [k*Width +: Width].
- i_last  input  NumReq  marks the current beat of requester k as the last beat of its burst.
- i_full  input  1  FIFO o_full.
- o_gnt  output  NumReq  one-hot registered grant.
- o_wr_en  output  1  FIFO write enable.
- o_wr_data  output  Width  FIFO write data.
- o_busy  output  1  high while in BURST.
- o_abort  output  1  one-cycle pulse when the owner drops i_req before finishing its burst.

Behaviour:
- Reset (asynchronous assert, synchronous release): state IDLE, o_gnt=0, o_busy=0, o_abort=0, beat_cnt=0, last_owner=NumReq-1 (so requester 0 has highest priority first). o_wr_en=0 and o_wr_data=0 follow combinationally.
- States: IDLE and BURST.
- IDLE:
  - If any i_req is high, pick the first asserted index scanning upward from last_owner+1, modulo NumReq.
  - Register o_gnt to that one-hot value, set last_owner to it, go to BURST with beat_cnt=0.
  - If no i_req is high, stay in IDLE.
  - The grant appears 1 cycle after the request is seen.
- Accept (combinational): accept = |(o_gnt & i_req) & ~i_full.
  - o_wr_en = accept.
  - o_wr_data = i_data of the granted index when o_gnt is nonzero, else 0.
  - A beat transfers on a rising clk edge where accept=1.
- BURST, evaluated each cycle in priority order:
  - Owner's i_req is low (abort): next state IDLE, o_gnt=0, o_abort=1 for one cycle. No write this cycle.
  - Accept and (owner i_last is high, or beat_cnt==MaxBurst-1): write occurs, next state IDLE, o_gnt=0, beat_cnt=0.
  - Accept otherwise: beat_cnt increments and the grant is held.
  - i_full is high: stall. No write, grant and beat_cnt are held, no timeout. Full never aborts or releases a burst.
- Bubble: there is exactly one idle cycle between consecutive bursts (the IDLE arbitration cycle), even when other requests are pending. Max throughput is MaxBurst beats per MaxBurst+1 cycles.
- Fairness: last_owner updates only at grant time. A requester that is continuously requesting is granted within NumReq-1 other bursts.
- Non-owners: their i_req, i_data and i_last are ignored. A requester that deasserts i_req while not granted loses nothing.
- beat_cnt width is $clog2(MaxBurst)+1 and never exceeds MaxBurst-1.
- MaxBurst=1: every accepted beat releases the grant.
- o_gnt is never multi-hot and never nonzero in IDLE. o_wr_en is never high when i_full=1.
- Reset mid-burst: takes effect immediately. Outputs go to their reset values; no partial-state recovery.

Test Plan:
- Reset, then only i_req[2] high with 3 beats (data 0xA0, 0xA1, 0xA2, i_last on 0xA2) -> o_gnt=4'b0100 one cycle after the request; o_wr_en high for 3 cycles with 0xA0..0xA2 in order; back to IDLE and o_busy=0 the cycle after the last beat.
- All four requesters continuously requesting with single-beat bursts (i_last always high) -> grant order 0,1,2,3,0,…; one write every 2 cycles; o_gnt is always one-hot.
- MaxBurst=16, requester 1 requests with i_last never high -> exactly 16 writes, then forced release; requester 1 is granted again only after the other pending requesters have had a grant.
- i_full high for 5 cycles during the 3rd beat of a burst -> o_wr_en=0 for those 5 cycles, o_gnt and beat_cnt held; data resumes with no loss or duplication, and the total write count matches the beats sent.
- Owner drops i_req after 2 beats (no i_last) -> o_abort pulses for 1 cycle, o_gnt=0 next cycle, no extra write; the next request is arbitrated normally.
- rst_n asserted mid-burst while i_full=0 -> o_gnt, o_wr_en and o_busy are 0 immediately; after release, with all requesters requesting, requester 0 is granted first.

Source files
------------

// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - burst-locked round-robin arbiter for an async FIFO write port
//
// Ports:
//   clk        write-domain clock (FIFO clk_wr)
//   rst_n      asynchronous active-low reset
//   i_req      per-requester request, held while the requester has data
//   i_data     per-requester data, requester k at [k*Width +: Width]
//   i_last     per-requester last-beat marker
//   i_full     FIFO full flag, used as backpressure
//   o_gnt      registered one-hot grant
//   o_wr_en    FIFO write enable
//   o_wr_data  FIFO write data (granted requester's data, else 0)
//   o_busy     high while a burst owns the port
//   o_abort    one-cycle pulse after the owner dropped its request mid-burst
module fifo_wr_arbiter #(
    parameter int NumReq   = 4,
    parameter int Width    = 8,
    parameter int MaxBurst = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NumReq-1:0]       i_req,
    input  logic [NumReq*Width-1:0] i_data,
    input  logic [NumReq-1:0]       i_last,
    input  logic                    i_full,
    output logic [NumReq-1:0]       o_gnt,
    output logic                    o_wr_en,
    output logic [Width-1:0]        o_wr_data,
    output logic                    o_busy,
    output logic                    o_abort
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int CntW = $clog2(MaxBurst) + 1;

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [NumReq-1:0]  gnt_q, gnt_d;
    logic [IdxW-1:0]    last_owner_q, last_owner_d;
    logic [CntW-1:0]    beat_cnt_q, beat_cnt_d;
    logic               abort_q, abort_d;

    logic               owner_req;
    logic               owner_last;
    logic               accept;
    logic               pick_valid;
    logic [IdxW-1:0]    pick_idx;
    logic [IdxW:0]      cand;

    // The grant is one-hot, so masking then OR-reducing selects the owner's bit.
    assign owner_req  = |(gnt_q & i_req);
    assign owner_last = |(gnt_q & i_last);
    assign accept     = owner_req & ~i_full;

    // Round-robin pick: scan upward starting one past the previous owner,
    // wrapping modulo NumReq, and take the first requester found.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 1; i <= NumReq; i++) begin
            cand = {1'b0, last_owner_q} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NumReq)) begin
                cand = cand - (IdxW + 1)'(NumReq);
            end
            if (!pick_valid && i_req[cand[IdxW-1:0]]) begin
                pick_valid = 1'b1;
                pick_idx   = cand[IdxW-1:0];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            gnt_q        <= '0;
            last_owner_q <= IdxW'(NumReq - 1);
            beat_cnt_q   <= '0;
            abort_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            last_owner_q <= last_owner_d;
            beat_cnt_q   <= beat_cnt_d;
            abort_q      <= abort_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        last_owner_d = last_owner_q;
        beat_cnt_d   = beat_cnt_q;
        abort_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    state_d      = S_BURST;
                    gnt_d        = NumReq'(1) << pick_idx;
                    last_owner_d = pick_idx;
                    beat_cnt_d   = '0;
                end
            end
            S_BURST: begin
                if (!owner_req) begin
                    state_d    = S_IDLE;
                    gnt_d      = '0;
                    beat_cnt_d = '0;
                    abort_d    = 1'b1;
                end else if (accept) begin
                    if (owner_last || beat_cnt_q == CntW'(MaxBurst - 1)) begin
                        state_d    = S_IDLE;
                        gnt_d      = '0;
                        beat_cnt_d = '0;
                    end else begin
                        beat_cnt_d = beat_cnt_q + CntW'(1);
                    end
                end
                // Full with the owner still requesting: hold everything.
            end
            default: begin
                state_d = S_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        o_gnt     = gnt_q;
        o_busy    = (state_q == S_BURST);
        o_abort   = abort_q;
        o_wr_en   = accept;
        o_wr_data = '0;
        for (int k = 0; k < NumReq; k++) begin
            o_wr_data = o_wr_data | (i_data[k*Width +: Width] & {Width{gnt_q[k]}});
        end
    end

endmodule
